updown_step_arbiter: RTL
========================

// Module: updown_step_arbiter
// PURPOSE
//  Shares one CW-bit up/down counter between NREQ requesters. Each request asks for LEN steps in one direction.
//  Round-robin arbitration; the winner's burst of step pulses runs to completion before the next grant.
//  Sits between the requesting agents and a counter with step-enable (cnt_step) and direction (cnt_up) inputs.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  CW    8  counter width; cnt_value width
//  LW    4  burst-length field width; max burst = 2**LW-1 steps
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-high reset
//  req_valid   in   NREQ     per-requester request valid
//  req_dir     in   NREQ     per-requester direction, 1=up, 0=down
//  req_len     in   NREQ*LW  per-requester step count; slice i = [i*LW +: LW]
//  req_ready   out  NREQ     one-hot accept strobe, combinational
//  cnt_value   in   CW       current counter value, fed back from the counter
//  cnt_step    out  1        counter advances one step this cycle
//  cnt_up      out  1        step direction, valid while cnt_step=1
//  busy        out  1        a burst is granted and not yet done
//  grant_id    out  clog2(NREQ)  index of the current/last winner
//  done        out  1        one-cycle pulse at end of each burst
//  sat_hit     out  1        sticky per burst; see CONFIGURATION
// BEHAVIOUR
//  Reset (async): FSM=IDLE; rr_ptr=0; all outputs 0; remaining=0.
//  FSM: IDLE -> RUN (len>0) | DONE (len==0); RUN -> DONE on last step; DONE -> IDLE.
//  IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   - req_ready[winner]=1 in the same cycle (combinational); accept = valid & ready.
//   - Latch dir, len and grant_id on accept. Set busy=1 from the next cycle.
//  Requester holds valid/dir/len stable until ready. Dropping valid before ready = request withdrawn, no error.
//  RUN: cnt_step=1 and cnt_up=dir every cycle; remaining decrements each cycle.
//   - Exactly LEN step cycles, back-to-back. Leave RUN after the cycle with remaining==1.
//  DONE: done=1, busy=0, cnt_step=0 for one cycle; rr_ptr=(grant_id+1) mod NREQ.
//  Back-to-back: at most one grant per LEN+2 cycles (IDLE, LEN x RUN, DONE).
//   - A LEN=0 burst takes 2 cycles: accept, then DONE.
//  req_ready is 0 in every state except IDLE. Requests arriving during RUN/DONE wait.
//  Wrap-around: with the macro off, the counter wraps freely (0xFF+1=0x00, 0x00-1=0xFF).
//   - This block does not inspect cnt_value.
//  Reset mid-burst: cnt_step drops asynchronously, the burst is abandoned, no done pulse, rr_ptr=0.
//  Only one requester is granted per cycle; simultaneous valids are resolved purely by rr_ptr.
// CONFIGURATION
//  UDSA_SAT_GUARD_EN defined:
//   - In RUN, suppress the step (cnt_step=0) when dir=up & cnt_value=all-ones, or dir=down & cnt_value=0.
//   - Set sat_hit=1 and end the burst early: go to DONE next cycle.
//   - sat_hit holds until the next accept or reset.
//  Not defined: sat_hit tied 0; bursts always run full LEN and the counter wraps.
// TESTING
//  T1 reset mid-RUN (req0 up len=5, reset at step 2) -> cnt_step=0 same cycle, busy=0, no done, next grant from req0.
//  T2 req1 up len=3, cnt=0x10 -> ready1 pulses once; 3 step cycles, cnt=0x13; done 1 cycle later; grant_id=1.
//  T3 all 4 valid, len=1 each, held -> grant order 0,1,2,3,0; each grant 3 cycles apart.
//  T4 req2 len=0 -> ready2 then done next cycle; cnt_step never asserted; rr_ptr=3.
//  T5 macro off, cnt=0xFE, up len=4 -> cnt=0x02, sat_hit=0.
//     Macro on, same stimulus -> 1 step, cnt=0xFF, sat_hit=1, done early.
//  T6 req0 withdraws valid while req3 is in RUN -> req0 never granted; req3 unaffected.

Source files
------------

// File: rtl/updown_step_arbiter.sv
// Round-robin arbiter that grants one requester a burst of up/down step pulses on a shared counter.
// Optional saturation guard: define UDSA_SAT_GUARD_EN to stop bursts at the counter limits.
module updown_step_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 8,
  parameter int unsigned LW   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_dir,
  input  logic [NREQ*LW-1:0]       req_len,
  output logic [NREQ-1:0]          req_ready,
  input  logic [CW-1:0]            cnt_value,
  output logic                     cnt_step,
  output logic                     cnt_up,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     done,
  output logic                     sat_hit
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic            dir_q, dir_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            sat_q, sat_d;

  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  cand;
  logic            win_dir;
  logic [LW-1:0]   win_len;
  logic            at_limit;

  // First valid requester scanning upward from rr_q, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_q) + k >= NREQ) ? (32'(rr_q) + k - NREQ) : (32'(rr_q) + k));
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner's payload.
  always_comb begin
    win_dir = 1'b0;
    win_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_dir = req_dir[i];
        win_len = req_len[i*LW +: LW];
      end
    end
  end

`ifdef UDSA_SAT_GUARD_EN
  assign at_limit = dir_q ? (cnt_value == {CW{1'b1}}) : (cnt_value == {CW{1'b0}});
`else
  logic cnt_unused;
  assign cnt_unused = ^cnt_value;
  assign at_limit   = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    sat_d     = sat_q;
    req_ready = '0;
    cnt_step  = 1'b0;
    cnt_up    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found && !reset) begin
          req_ready = NREQ'(1) << win_idx;
          gid_d     = win_idx;
          dir_d     = win_dir;
          rem_d     = win_len;
          sat_d     = 1'b0;
          state_d   = (win_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (at_limit) begin
          // Step would wrap past the limit: drop it and close the burst.
          sat_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_step = 1'b1;
          cnt_up   = dir_q;
          rem_d    = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        rr_d    = (32'(gid_q) == NREQ - 1) ? '0 : gid_q + IDW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
    end
  end

  // Status outputs decode straight from flops; sat_q stays 0 without the guard.
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign grant_id = gid_q;
  assign sat_hit  = sat_q;

endmodule
